turbo_frame_assembler: RTL and testbench
========================================

Name: turbo_frame_assembler

Overview:
Upstream neighbour of turbo_decoder. Collects a serial stream of received soft symbol pairs (systematic, parity) into complete N-symbol frames. Presents each frame as one wide word in the decoder's `r` layout. Ping-pong double buffering lets the next frame fill while the current one waits for the decoder to accept it.

Parameters:
N, 256, symbol pairs per frame (decoder block size)
W, 1, bits per soft value; W=1 gives out_r width 2*N, matching decoder `r`
CW, 16, width of frame_cnt

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
in_valid  input  1  upstream symbol pair valid
in_ready  output  1  assembler can accept a pair this cycle
in_sys  input  W  systematic soft value
in_par  input  W  parity soft value
in_sof  input  1  pair is symbol 0 of a new frame
out_valid  output  1  a full frame is presented on out_r
out_ready  input  1  decoder accepts the frame
out_r  output  2*N*W  frame; pair i: sys at [2*i*W +: W], par at [(2*i+1)*W +: W]
frame_drop  output  1  one-cycle pulse when a partial frame is abandoned
frame_cnt  output  CW  count of frames delivered, wraps modulo 2^CW

Behaviour:
- Storage: two banks (0/1), each 2*N*W bits, each with a full flag.
- Pointers: wr_bank, rd_bank (1 bit each) and wr_idx (0..N-1).
- Reset (reset==0 at posedge):
  - Full flags cleared; wr_bank=rd_bank=0; wr_idx=0.
  - Bank data cleared to 0.
  - Outputs: out_valid=0, out_r=0, frame_drop=0, frame_cnt=0, in_ready=0 during reset.
  - Reset mid-frame discards partial and full frames silently; no frame_drop pulse.
- in_ready = !full[wr_bank], driven from registers only. No combinational path from out_ready or in_valid.
- Accept = in_valid & in_ready. Per accepted pair:
  - wr_idx==0, in_sof=0: pair discarded (hunting for frame start). No state change, no flag.
  - wr_idx==0, in_sof=1: stored at index 0; wr_idx=1.
  - wr_idx>0, in_sof=0: stored at wr_idx; wr_idx increments.
  - wr_idx>0, in_sof=1: partial frame abandoned. frame_drop=1 next cycle (one cycle). Pair stored at index 0; wr_idx=1. Stale data at higher indices is overwritten before the frame completes.
  - Storing at index N-1: full[wr_bank] set; wr_bank toggles; wr_idx=0. With N=1, an in_sof pair completes the frame immediately.
- Output side:
  - out_valid = full[rd_bank].
  - out_r = bank[rd_bank]; stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: full[rd_bank] cleared, rd_bank toggles, frame_cnt increments (wraps from 2^CW-1 to 0).
- Latency: last pair accepted at edge t -> out_valid=1 after edge t (visible cycle t+1).
- Freed bank: becomes writable (in_ready=1) the cycle after the output handshake.
- Simultaneous events:
  - Completing one bank and releasing the other in the same cycle: both take effect.
  - Both banks full: in_ready=0; upstream stalls until release.
- Ordering: frames are delivered strictly in completion order; no frame is ever lost once full.

Test Plan:
- N=4,W=2: reset low 2 cycles -> in_ready=0, out_valid=0, out_r=0, frame_cnt=0. Release reset -> in_ready=1 next cycle.
- N=4,W=2, out_ready=1: send sof + pairs (sys,par) = (1,2),(3,0),(2,1),(0,3) back-to-back. Expected: out_valid one cycle after 4th accept; out_r=16'b11_00_01_10_00_11_10_01 (MSB first); frame_cnt=1.
- out_ready=0, send 3 full frames continuously:
  - frames 1–2 fill both banks; in_ready drops after 8th accept; out_r holds frame 1.
  - raise out_ready for 1 cycle: out_r switches to frame 2; in_ready=1 the following cycle; frame 3 fills bank 0.
- Send sof + 2 pairs, then sof + 4 pairs (values 5,6,7,4 in sys; W=3 run). Expected: frame_drop pulses exactly once; delivered frame contains only the second frame's values.
- Pairs with in_sof=0 before any sof are discarded; out_valid stays 0 until 4 pairs following an sof arrive.
- Assert reset for 1 cycle with 2 pairs buffered and one full bank. Expected: out_valid=0, frame_cnt=0, no frame_drop. Next frame assembles from index 0 correctly.
- CW=2: deliver 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/turbo_frame_assembler.sv
// Ping-pong frame assembler: gathers N serial (sys, par) soft-value pairs into
// one wide word in turbo_decoder `r` layout while the other bank waits for the decoder.
module turbo_frame_assembler #(
  parameter int N  = 256,
  parameter int W  = 1,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_sys,
  input  logic [W-1:0]      in_par,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N*W-1:0]  out_r,
  output logic              frame_drop,
  output logic [CW-1:0]     frame_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = 2 * N * W;

  typedef logic [FW-1:0] frame_t;
  typedef logic [IW-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  frame_t        bank_q [2];
  frame_t        bank_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  idx_t          wr_idx_q, wr_idx_d;
  logic          in_ready_q, in_ready_d;
  logic          frame_drop_q, frame_drop_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  logic accept;
  logic release_frame;
  logic store;
  idx_t slot;

  assign accept        = in_valid & in_ready_q;
  assign release_frame = full_q[rd_bank_q] & out_ready;
  // A non-sof pair with no frame open is dropped silently while hunting for a start.
  assign store         = accept & (in_sof | (wr_idx_q != '0));
  assign slot          = in_sof ? '0 : wr_idx_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    bank_d       = bank_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    frame_cnt_d  = frame_cnt_q;
    frame_drop_d = accept & in_sof & (wr_idx_q != '0);

    if (release_frame) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      frame_cnt_d       = frame_cnt_q + CW'(1);
    end

    // Release and completion always hit different banks: one needs the bank full, the other empty.
    if (store) begin
      bank_d[wr_bank_q][2 * int'(slot) * W +: W]       = in_sys;
      bank_d[wr_bank_q][(2 * int'(slot) + 1) * W +: W] = in_par;
      if (slot == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = slot + idx_t'(1);
      end
    end

    // Registered so in_ready has no combinational path from in_valid/out_ready and stays low in reset.
    in_ready_d = ~full_d[wr_bank_d];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      // NOTE: bank storage is cleared on reset so out_r reads zero until the first frame lands.
      bank_q[0]    <= '0;
      bank_q[1]    <= '0;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      in_ready_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      in_ready_q   <= in_ready_d;
      frame_drop_q <= frame_drop_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = full_q[rd_bank_q];
  assign out_r      = bank_q[rd_bank_q];
  assign frame_drop = frame_drop_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_turbo_frame_assembler.sv
// Bench for turbo_frame_assembler: directed scenarios plus a random run checked
// against a queue-of-frames reference model; a second N=1 instance covers single-pair frames.
module tb_turbo_frame_assembler;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int CW = 2;
  localparam int FW = 2 * N * W;

  typedef logic [FW-1:0] frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, in_sof;
  logic [W-1:0]  in_sys, in_par;
  logic          out_valid, out_ready, frame_drop;
  frame_t        out_r;
  logic [CW-1:0] frame_cnt;

  logic       v1, rdy1, sof1, ov1, ordy1, drop1;
  logic [1:0] sys1, par1;
  logic [3:0] out_r1;
  logic [3:0] cnt1;

  turbo_frame_assembler #(.N(N), .W(W), .CW(CW)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sys(in_sys), .in_par(in_par), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .frame_drop(frame_drop), .frame_cnt(frame_cnt)
  );

  turbo_frame_assembler #(.N(1), .W(2), .CW(4)) u_dut_n1 (
    .clk(clk), .reset(reset),
    .in_valid(v1), .in_ready(rdy1), .in_sys(sys1), .in_par(par1), .in_sof(sof1),
    .out_valid(ov1), .out_ready(ordy1), .out_r(out_r1),
    .frame_drop(drop1), .frame_cnt(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: completed frames wait in a FIFO of depth two; a partial frame grows pair by pair.
  frame_t        done_q[$];
  frame_t        part_word;
  int            part_len;
  logic [CW-1:0] m_cnt;
  logic          m_live;
  logic          m_drop;
  logic          m_acc;

  function automatic logic m_ready();
    return m_live && (done_q.size() < 2);
  endfunction

  function automatic frame_t m_head();
    return (done_q.size() > 0) ? done_q[0] : '0;
  endfunction

  task automatic step(input logic v, input logic sof, input logic [W-1:0] s,
                      input logic [W-1:0] p, input logic ordy);
    logic   acc, hs;
    frame_t tmp;
    in_valid  = v;
    in_sof    = sof;
    in_sys    = s;
    in_par    = p;
    out_ready = ordy;
    acc = v && m_ready();
    hs  = (done_q.size() > 0) && ordy;
    @(posedge clk);
    #1;
    m_drop = 1'b0;
    if (hs) begin
      tmp   = done_q.pop_front();
      m_cnt = m_cnt + 1'b1;
    end
    if (acc && (sof || part_len > 0)) begin
      if (sof) begin
        m_drop    = (part_len > 0);
        part_word = '0;
        part_len  = 0;
      end
      part_word[2 * part_len * W +: W]       = s;
      part_word[(2 * part_len + 1) * W +: W] = p;
      part_len++;
      if (part_len == N) begin
        done_q.push_back(part_word);
        part_len = 0;
      end
    end
    m_acc  = acc;
    m_live = 1'b1;
  endtask

  task automatic send(input logic sof, input logic [W-1:0] s, input logic [W-1:0] p,
                      input logic ordy);
    int tries = 0;
    do begin
      step(1'b1, sof, s, p, ordy);
      tries++;
    end while (!m_acc && tries < 20);
    n_checks++;
    if (!m_acc) begin
      n_errors++;
      $display("FAIL send_timeout: pair not accepted after %0d cycles", tries);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_sys    = '0;
    in_par    = '0;
    out_ready = 1'b0;
    v1 = 1'b0; sof1 = 1'b0; sys1 = '0; par1 = '0; ordy1 = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    done_q.delete();
    part_word = '0;
    part_len  = 0;
    m_cnt     = '0;
    m_live    = 1'b0;
    m_drop    = 1'b0;
    m_acc     = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_checks += 5;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_r !== '0) begin n_errors++; $display("FAIL reset_out_r: got %h want 0", out_r); end
    if (frame_cnt !== '0) begin n_errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    if (frame_drop !== 1'b0) begin n_errors++; $display("FAIL reset_frame_drop: got %b want 0", frame_drop); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single_frame();
    int     sv[4] = '{1, 3, 2, 0};
    int     pv[4] = '{2, 0, 1, 3};
    frame_t exp_r = {3'd3, 3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < 4; i++) begin
      send(i == 0, W'(sv[i]), W'(pv[i]), 1'b1);
      n_checks++;
      if (out_valid !== (i == 3)) begin
        n_errors++;
        $display("FAIL single_latency pair %0d: out_valid got %b want %b", i, out_valid, i == 3);
      end
    end
    n_checks += 2;
    if (out_r !== exp_r) begin n_errors++; $display("FAIL single_out_r: got %h want %h", out_r, exp_r); end
    if (frame_cnt !== 2'd0) begin n_errors++; $display("FAIL single_cnt_before: got %0d want 0", frame_cnt); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks += 2;
    if (frame_cnt !== 2'd1) begin n_errors++; $display("FAIL single_cnt_after: got %0d want 1", frame_cnt); end
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int     fs[3][4];
    int     fp[3][4];
    frame_t f[3];
    for (int k = 0; k < 3; k++) begin
      f[k] = '0;
      for (int i = 0; i < 4; i++) begin
        fs[k][i] = int'($urandom_range(0, 7));
        fp[k][i] = int'($urandom_range(0, 7));
        f[k][2 * i * W +: W]       = W'(fs[k][i]);
        f[k][(2 * i + 1) * W +: W] = W'(fp[k][i]);
      end
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        send(i == 0, W'(fs[k][i]), W'(fp[k][i]), 1'b0);
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full_in_ready: got %b want 0", in_ready); end
    if (out_r !== f[0]) begin n_errors++; $display("FAIL bp_hold_frame1: got %h want %h", out_r, f[0]); end
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, W'(fs[2][0]), W'(fp[2][0]), 1'b0);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_r !== f[0]) begin
        n_errors++;
        $display("FAIL bp_stall cycle %0d: rdy=%b vld=%b r=%h want rdy=0 vld=1 r=%h", c, in_ready, out_valid, out_r, f[0]);
      end
    end
    step(1'b1, 1'b1, W'(fs[2][0]), W'(fp[2][0]), 1'b1);
    n_checks += 2;
    if (out_r !== f[1]) begin n_errors++; $display("FAIL bp_switch_frame2: got %h want %h", out_r, f[1]); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_freed_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++)
      send(i == 0, W'(fs[2][i]), W'(fp[2][i]), 1'b0);
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_refill_in_ready: got %b want 0", in_ready); end
    if (out_r !== f[1]) begin n_errors++; $display("FAIL bp_still_frame2: got %h want %h", out_r, f[1]); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if (out_r !== f[2]) begin n_errors++; $display("FAIL bp_frame3: got %h want %h", out_r, f[2]); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drained: out_valid got %b want 0", out_valid); end
    if (frame_cnt !== m_cnt) begin n_errors++; $display("FAIL bp_cnt: got %0d want %0d", frame_cnt, m_cnt); end
  endtask

  task automatic test_drop();
    int     ss[7]  = '{1, 2, 3, 5, 6, 7, 4};
    int     ps[7]  = '{1, 2, 3, 1, 2, 3, 0};
    int     pulses = 0;
    frame_t exp_r  = {3'd0, 3'd4, 3'd3, 3'd7, 3'd2, 3'd6, 3'd1, 3'd5};
    for (int i = 0; i < 7; i++) begin
      send(i == 0 || i == 3, W'(ss[i]), W'(ps[i]), 1'b0);
      if (frame_drop === 1'b1) pulses++;
      n_checks++;
      if (frame_drop !== (i == 3)) begin
        n_errors++;
        $display("FAIL drop_pulse pair %0d: got %b want %b", i, frame_drop, i == 3);
      end
    end
    step(1'b0, 1'b0, '0, '0, 1'b0);
    if (frame_drop === 1'b1) pulses++;
    n_checks += 3;
    if (pulses != 1) begin n_errors++; $display("FAIL drop_count: got %0d want 1", pulses); end
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL drop_out_valid: got %b want 1", out_valid); end
    if (out_r !== exp_r) begin n_errors++; $display("FAIL drop_out_r: got %h want %h", out_r, exp_r); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_hunt();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_drop !== 1'b0) begin
        n_errors++;
        $display("FAIL hunt_discard %0d: rdy=%b vld=%b drop=%b want 1 0 0", c, in_ready, out_valid, frame_drop);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(i == 0, W'($urandom), W'($urandom), 1'b0);
      n_checks++;
      if (out_valid !== (i == 3)) begin
        n_errors++;
        $display("FAIL hunt_valid pair %0d: got %b want %b", i, out_valid, i == 3);
      end
    end
    n_checks++;
    if (out_r !== m_head()) begin n_errors++; $display("FAIL hunt_out_r: got %h want %h", out_r, m_head()); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int     sv[4] = '{7, 1, 6, 2};
    int     pv[4] = '{0, 5, 3, 4};
    frame_t exp_r = {3'd4, 3'd2, 3'd3, 3'd6, 3'd5, 3'd1, 3'd0, 3'd7};
    for (int i = 0; i < 6; i++)
      send(i == 0 || i == 4, W'($urandom), W'($urandom), 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_setup: out_valid got %b want 1", out_valid); end
    do_reset(1);
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    if (frame_cnt !== '0) begin n_errors++; $display("FAIL rmid_frame_cnt: got %0d want 0", frame_cnt); end
    if (frame_drop !== 1'b0) begin n_errors++; $display("FAIL rmid_frame_drop: got %b want 0", frame_drop); end
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    step(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(i == 0, W'(sv[i]), W'(pv[i]), 1'b0);
      n_checks++;
      if (frame_drop !== 1'b0) begin n_errors++; $display("FAIL rmid_no_drop pair %0d: got %b want 0", i, frame_drop); end
    end
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_refill_valid: got %b want 1", out_valid); end
    if (out_r !== exp_r) begin n_errors++; $display("FAIL rmid_refill_r: got %h want %h", out_r, exp_r); end
    step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    int seq[5] = '{1, 2, 3, 0, 1};
    do_reset(1);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++)
        send(i == 0, W'($urandom), W'($urandom), 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n_checks++;
      if (frame_cnt !== CW'(seq[k])) begin
        n_errors++;
        $display("FAIL wrap_cnt frame %0d: got %0d want %0d", k, frame_cnt, seq[k]);
      end
    end
  endtask

  task automatic test_random();
    frame_t exp_r;
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, W'($urandom), W'($urandom),
           $urandom_range(0, 2) == 0);
      exp_r = m_head();
      n_checks++;
      if (in_ready !== m_ready() || out_valid !== (done_q.size() > 0) || frame_drop !== m_drop ||
          frame_cnt !== m_cnt || (done_q.size() > 0 && out_r !== exp_r)) begin
        n_errors++;
        $display("FAIL random cycle %0d: rdy=%b vld=%b drop=%b cnt=%0d r=%h want rdy=%b vld=%b drop=%b cnt=%0d r=%h",
                 c, in_ready, out_valid, frame_drop, frame_cnt, out_r,
                 m_ready(), done_q.size() > 0, m_drop, m_cnt, exp_r);
      end
    end
  endtask

  task automatic test_n1();
    in_valid = 1'b0; out_ready = 1'b0;
    ordy1 = 1'b0;
    v1 = 1'b1; sof1 = 1'b1; sys1 = 2'd1; par1 = 2'd2;
    @(posedge clk); #1;
    n_checks++;
    if (ov1 !== 1'b1 || out_r1 !== 4'b1001 || rdy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL n1_first: vld=%b r=%b rdy=%b want 1 1001 1", ov1, out_r1, rdy1);
    end
    sof1 = 1'b0; sys1 = 2'd3; par1 = 2'd3;
    @(posedge clk); #1;
    n_checks++;
    if (rdy1 !== 1'b1 || drop1 !== 1'b0 || out_r1 !== 4'b1001) begin
      n_errors++;
      $display("FAIL n1_hunt: rdy=%b drop=%b r=%b want 1 0 1001", rdy1, drop1, out_r1);
    end
    sof1 = 1'b1; sys1 = 2'd2; par1 = 2'd3;
    @(posedge clk); #1;
    n_checks++;
    if (rdy1 !== 1'b0 || drop1 !== 1'b0) begin
      n_errors++;
      $display("FAIL n1_both_full: rdy=%b drop=%b want 0 0", rdy1, drop1);
    end
    v1 = 1'b0; ordy1 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_r1 !== 4'b1110 || cnt1 !== 4'd1 || rdy1 !== 1'b1) begin
      n_errors++;
      $display("FAIL n1_release: r=%b cnt=%0d rdy=%b want 1110 1 1", out_r1, cnt1, rdy1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ov1 !== 1'b0 || cnt1 !== 4'd2) begin
      n_errors++;
      $display("FAIL n1_drain: vld=%b cnt=%0d want 0 2", ov1, cnt1);
    end
    ordy1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_drop();
    test_hunt();
    test_reset_mid();
    test_wrap();
    test_random();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
